core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control sequencer for the RV32I core. It owns the PC, fetches instructions over a ready-handshaked instruction-memory port, and holds the instruction register stable while the registered decode stage settles. It then gates the decode stage's control outputs into per-phase strobes for ALU, data memory and register-file writeback. It sits between the memories and the decode/execute datapath and retires one instruction at a time.

## Interface
- RESET_PC, 16'h0000: PC loaded on reset.
- PC_W, 16: PC/address width; matches the decode stage's `pc` input.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  instruction register, drives decode `instruction`.
- pc  out  PC_W  current PC, drives decode `pc`.
- dec_wEn, dec_mem_wEn, dec_wb_sel, dec_next_PC_select  in  1 each  decode control outputs.
- target_pc  in  PC_W  branch/jump target from ALU.
- alu_en  out  1  ALU result capture strobe.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  data-memory write (store).
- dmem_ready  in  1  data-memory access complete.
- rf_wEn  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE, HALTED, TRAP.
- halted  out  1  high in HALTED.
- trap  out  1  high in TRAP (sticky until rst).
- instret  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DEC1, DEC2, EXEC, MEM, WB, HALTED, TRAP.
- Reset: state=IDLE, pc=RESET_PC, ir=0, instret=0; all strobes, busy, halted, trap = 0.
- IDLE -> FETCH unconditionally next cycle.
- FETCH: imem_req=1, imem_addr=pc held stable; on imem_ready: ir<=imem_rdata, -> DEC1. No timeout.
- DEC1, DEC2: ir stable; decode registers fields in DEC1 and controls in DEC2; dec_* inputs valid from EXEC onward.
- EXEC: alu_en=1 for one cycle. Checks: ir[6:0] not in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0010111, 0110111} -> TRAP. Else load (dec_wb_sel=1) or store (dec_mem_wEn=1) -> MEM. Else -> WB.
- MEM: dmem_req=1, dmem_we=dec_mem_wEn, held until dmem_ready; then -> WB.
- WB: rf_wEn=dec_wEn for one cycle; instret+=1 (wraps mod 2^32). pc<=dec_next_PC_select ? target_pc : pc+4 (mod 2^PC_W). If dec_next_PC_select and target_pc[1:0]!=0 -> TRAP (pc unchanged, no rf write, no instret increment). Else if halt -> HALTED. Else -> FETCH.
- HALTED: halted=1; halt=0 -> FETCH at current pc.
- TRAP: trap=1, all strobes 0; exits only via rst.
- Simultaneous: misaligned target and halt in WB -> TRAP wins.
- halt outside WB is ignored until the next WB.
- rst mid-FETCH/MEM: requests drop asynchronously; the memory side discards the in-flight access.

## Timing
- Strobes (imem_req, alu_en, dmem_req, dmem_we, rf_wEn) are Moore outputs of state; no combinational path from *_ready to any output.
- Non-memory instruction, imem_ready in first FETCH cycle: 5 cycles FETCH->WB; next FETCH on cycle 6.
- Load/store with dmem_ready in first MEM cycle: 6 cycles.
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle.
- pc and instret update on the clock edge ending WB; ir updates only on the edge ending an accepted FETCH.

## Structure
- Shared package core_pkg: state encoding, the nine opcode constants (shared with decode), PC_W default.
- No sub-module; instret counter and PC incrementer are inline.

## Test plan
- Reset with RESET_PC=16'h0100, imem_ready tied 1, ADDI fetched: imem_addr=0x0100; rf_wEn pulses on cycle 5; next imem_addr=0x0104; instret=1.
- SW with dmem_ready delayed 3 cycles: dmem_req/dmem_we high 4 cycles; rf_wEn stays 0; retire on cycle 9.
- JAL with dec_next_PC_select=1, target_pc=0x0040: next imem_addr=0x0040. Same with target_pc=0x0042: trap=1, pc unchanged, instret unchanged.
- Opcode 7'b1111111: TRAP entered from EXEC; no dmem_req, no rf_wEn; stays in TRAP until rst.
- halt high during WB with pc=0xFFFC, no branch: halted=1, pc=0x0000 (wrap). halt low: fetch from 0x0000.
- rst asserted mid-MEM: dmem_req falls immediately; after release: IDLE then FETCH at RESET_PC, instret=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core control path: sequencer state encoding,
// the base-ISA major opcodes (also used by decode) and the default PC width.
package core_pkg;

    localparam int DEFAULT_PC_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DEC1,
        ST_DEC2,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memory subsystem (slave).
interface core_sequencer_if #(
    parameter int PC_W = core_pkg::DEFAULT_PC_W
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: owns PC/IR/instret, walks each instruction
// through FETCH, DEC1, DEC2, EXEC, (MEM), WB and emits per-phase strobes.
module core_sequencer
    import core_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    core_sequencer_if.master  mem,
    output logic [31:0]       ir,
    output logic [PC_W-1:0]   pc,
    input  logic              dec_wEn,
    input  logic              dec_mem_wEn,
    input  logic              dec_wb_sel,
    input  logic              dec_next_PC_select,
    input  logic [PC_W-1:0]   target_pc,
    output logic              alu_en,
    output logic              rf_wEn,
    output logic              busy,
    output logic              halted,
    output logic              trap,
    output logic [31:0]       instret
);

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [31:0]     instret_q;
    logic            wb_misaligned;
    logic            retire;

    // A taken branch/jump to a non-word-aligned target faults instead of retiring.
    assign wb_misaligned = dec_next_PC_select && (target_pc[1:0] != 2'b00);
    assign retire        = (state_q == ST_WB) && !wb_misaligned;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (mem.imem_ready) state_d = ST_DEC1;
            ST_DEC1:  state_d = ST_DEC2;
            ST_DEC2:  state_d = ST_EXEC;
            ST_EXEC: begin
                if (!is_rv32i_opcode(ir_q[6:0])) begin
                    state_d = ST_TRAP;
                end else if (dec_wb_sel || dec_mem_wEn) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM:   if (mem.dmem_ready) state_d = ST_WB;
            ST_WB: begin
                if (wb_misaligned) begin
                    state_d = ST_TRAP;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: if (!halt) state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes depend only on state (plus decode qualifiers), never on *_ready.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        alu_en       = 1'b0;
        rf_wEn       = 1'b0;
        busy         = 1'b1;
        halted       = 1'b0;
        trap         = 1'b0;
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_FETCH:  mem.imem_req = 1'b1;
            ST_EXEC:   alu_en = 1'b1;
            ST_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = dec_mem_wEn;
            end
            ST_WB:     rf_wEn = dec_wEn && !wb_misaligned;
            ST_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            ST_TRAP: begin
                busy = 1'b0;
                trap = 1'b1;
            end
            default:   busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else if (retire) begin
            pc_q      <= dec_next_PC_select ? target_pc : pc_q + PC_W'(4);
            instret_q <= instret_q + 32'd1;
        end
    end

    // IR only moves on an accepted fetch so decode sees a stable word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else if (state_q == ST_FETCH && mem.imem_ready) begin
            ir_q <= mem.imem_rdata;
        end
    end

    assign mem.imem_addr = pc_q;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected memory/retire
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_core_sequencer;

    localparam int PC_W = 16;

    typedef enum logic [2:0] {EV_FETCH, EV_DMEM, EV_RF, EV_TRAP, EV_HALT} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] data;
    } ev_t;

    logic            clk;
    logic            rst;
    logic            halt;
    logic [31:0]     ir;
    logic [PC_W-1:0] pc;
    logic            dec_wEn;
    logic            dec_mem_wEn;
    logic            dec_wb_sel;
    logic            dec_next_PC_select;
    logic [PC_W-1:0] target_pc;
    logic            alu_en;
    logic            rf_wEn;
    logic            busy;
    logic            halted;
    logic            trap;
    logic [31:0]     instret;

    int  total = 0;
    int  bad   = 0;
    ev_t exp_q[$];

    core_sequencer_if #(.PC_W(PC_W)) mif ();

    core_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (16'h0100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .halt               (halt),
        .mem                (mif.master),
        .ir                 (ir),
        .pc                 (pc),
        .dec_wEn            (dec_wEn),
        .dec_mem_wEn        (dec_mem_wEn),
        .dec_wb_sel         (dec_wb_sel),
        .dec_next_PC_select (dec_next_PC_select),
        .target_pc          (target_pc),
        .alu_en             (alu_en),
        .rf_wEn             (rf_wEn),
        .busy               (busy),
        .halted             (halted),
        .trap               (trap),
        .instret            (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic void push(input ev_kind_e kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Monitor: at most one event per cycle since each belongs to a distinct state.
    initial begin
        ev_t  got;
        ev_t  exp;
        logic seen;
        logic prev_trap;
        logic prev_halted;
        prev_trap   = 1'b0;
        prev_halted = 1'b0;
        forever begin
            @(negedge clk);
            seen = 1'b1;
            if (mif.imem_req && mif.imem_ready) begin
                got.kind = EV_FETCH; got.data = 32'(mif.imem_addr);
            end else if (mif.dmem_req && mif.dmem_ready) begin
                got.kind = EV_DMEM;  got.data = 32'(mif.dmem_we);
            end else if (rf_wEn) begin
                got.kind = EV_RF;    got.data = 32'(pc);
            end else if (trap && !prev_trap) begin
                got.kind = EV_TRAP;  got.data = 32'(pc);
            end else if (halted && !prev_halted) begin
                got.kind = EV_HALT;  got.data = 32'(pc);
            end else begin
                seen = 1'b0;
            end
            prev_trap   = trap;
            prev_halted = halted;
            if (seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(got.kind), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("event_kind", 32'(got.kind), 32'(exp.kind));
                    check("event_data", got.data, exp.data);
                end
            end
        end
    end

    task automatic wait_fetch();
        int guard;
        guard = 0;
        while (!mif.imem_req && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("fetch_reached", 32'(mif.imem_req), 32'd1);
    endtask

    // Runs one instruction from its FETCH until the next FETCH/HALTED/TRAP.
    task automatic issue(input logic [31:0] instr, input logic wb_sel, input logic mem_we,
                         input logic wen, input logic npc_sel, input logic [PC_W-1:0] tgt,
                         input int iwait, input int dwait,
                         output int cycles, output int dreq, output int alu);
        int guard;
        mif.imem_rdata     = instr;
        dec_wb_sel         = wb_sel;
        dec_mem_wEn        = mem_we;
        dec_wEn            = wen;
        dec_next_PC_select = npc_sel;
        target_pc          = tgt;
        mif.imem_ready     = 1'b0;
        mif.dmem_ready     = 1'b0;
        cycles = 0; dreq = 0; alu = 0;
        wait_fetch();
        repeat (iwait) begin
            @(posedge clk); #1;
            cycles++;
        end
        mif.imem_ready = 1'b1;
        @(posedge clk); #1;
        cycles++;
        mif.imem_ready = 1'b0;
        guard = 0;
        while (!(mif.imem_req || halted || trap) && guard < 100) begin
            if (alu_en) alu++;
            if (mif.dmem_req) begin
                dreq++;
                mif.dmem_ready = (dreq > dwait);
            end else begin
                mif.dmem_ready = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            guard++;
        end
        mif.dmem_ready = 1'b0;
        check("instr_done", 32'(mif.imem_req || halted || trap), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'h0100);
        check("rst_ir", ir, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_outputs", {27'h0, busy, halted, trap, mif.imem_req, mif.dmem_req | alu_en | rf_wEn | mif.dmem_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0011_2023;
    localparam logic [31:0] I_LW   = 32'h0001_2183;
    localparam logic [31:0] I_JAL  = 32'h0400_00EF;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    initial begin
        int cyc;
        int dreq;
        int alu;
        int guard;
        rst = 1'b1; halt = 1'b0;
        dec_wEn = 1'b0; dec_mem_wEn = 1'b0; dec_wb_sel = 1'b0; dec_next_PC_select = 1'b0;
        target_pc = '0;
        mif.imem_ready = 1'b0; mif.imem_rdata = '0; mif.dmem_ready = 1'b0;
        do_reset();

        // ADDI, no waits: 5 cycles FETCH..WB
        push(EV_FETCH, 32'h0100); push(EV_RF, 32'h0100);
        issue(I_ADDI, 0, 0, 1, 0, '0, 0, 0, cyc, dreq, alu);
        check("addi_cycles", 32'(cyc), 32'd5);
        check("addi_alu", 32'(alu), 32'd1);
        check("addi_ir", ir, I_ADDI);
        check("addi_pc", 32'(pc), 32'h0104);
        check("addi_instret", instret, 32'd1);

        // SW with dmem_ready delayed 3 cycles: 9 cycles, 4 request cycles, no rf write
        push(EV_FETCH, 32'h0104); push(EV_DMEM, 32'd1);
        issue(I_SW, 0, 1, 0, 0, '0, 0, 3, cyc, dreq, alu);
        check("sw_cycles", 32'(cyc), 32'd9);
        check("sw_dreq", 32'(dreq), 32'd4);
        check("sw_pc", 32'(pc), 32'h0108);
        check("sw_instret", instret, 32'd2);

        // LW with two imem wait cycles: 6 + 2
        push(EV_FETCH, 32'h0108); push(EV_DMEM, 32'd0); push(EV_RF, 32'h0108);
        issue(I_LW, 1, 0, 1, 0, '0, 2, 0, cyc, dreq, alu);
        check("lw_cycles", 32'(cyc), 32'd8);
        check("lw_pc", 32'(pc), 32'h010C);
        check("lw_instret", instret, 32'd3);

        // JAL to aligned target
        push(EV_FETCH, 32'h010C); push(EV_RF, 32'h010C);
        issue(I_JAL, 0, 0, 1, 1, 16'h0040, 0, 0, cyc, dreq, alu);
        check("jal_pc", 32'(pc), 32'h0040);
        check("jal_instret", instret, 32'd4);

        // JAL to misaligned target: trap, nothing retires
        push(EV_FETCH, 32'h0040); push(EV_TRAP, 32'h0040);
        issue(I_JAL, 0, 0, 1, 1, 16'h0042, 0, 0, cyc, dreq, alu);
        check("mis_cycles", 32'(cyc), 32'd5);
        check("mis_pc", 32'(pc), 32'h0040);
        check("mis_instret", instret, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        check("mis_trap_sticky", {30'h0, trap, busy}, 32'h2);
        do_reset();

        // Illegal opcode traps from EXEC even with load/store controls asserted
        push(EV_FETCH, 32'h0100); push(EV_TRAP, 32'h0100);
        issue(I_BAD, 1, 1, 1, 0, '0, 0, 0, cyc, dreq, alu);
        check("bad_cycles", 32'(cyc), 32'd4);
        check("bad_instret", instret, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_trap_sticky", {30'h0, trap, busy}, 32'h2);
        do_reset();

        // Jump to 0xFFFC, then halt during WB of an ADDI there: pc wraps to 0
        push(EV_FETCH, 32'h0100); push(EV_RF, 32'h0100);
        issue(I_JAL, 0, 0, 1, 1, 16'hFFFC, 0, 0, cyc, dreq, alu);
        check("wrap_jump_pc", 32'(pc), 32'hFFFC);
        halt = 1'b1;
        push(EV_FETCH, 32'hFFFC); push(EV_RF, 32'hFFFC); push(EV_HALT, 32'h0000);
        issue(I_ADDI, 0, 0, 1, 0, '0, 0, 0, cyc, dreq, alu);
        check("halt_state", {29'h0, halted, busy, trap}, 32'h4);
        check("halt_pc", 32'(pc), 32'h0000);
        check("halt_instret", instret, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold", 32'(halted), 32'd1);
        halt = 1'b0;
        push(EV_FETCH, 32'h0000); push(EV_RF, 32'h0000);
        issue(I_ADDI, 0, 0, 1, 0, '0, 0, 0, cyc, dreq, alu);
        check("resume_pc", 32'(pc), 32'h0004);
        check("resume_instret", instret, 32'd3);

        // Reset in the middle of a load's MEM phase
        push(EV_FETCH, 32'h0004);
        mif.imem_rdata = I_LW; dec_wb_sel = 1'b1; dec_mem_wEn = 1'b0; dec_wEn = 1'b1;
        dec_next_PC_select = 1'b0;
        wait_fetch();
        mif.imem_ready = 1'b1;
        @(posedge clk); #1;
        mif.imem_ready = 1'b0;
        guard = 0;
        while (!mif.dmem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mem_reached", 32'(mif.dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_dmem_drop", 32'(mif.dmem_req), 32'd0);
        check("rst_mid_instret", instret, 32'd0);
        check("rst_mid_pc", 32'(pc), 32'h0100);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_idle", {30'h0, mif.imem_req, busy}, 32'h0);
        @(posedge clk); #1;
        check("post_rst_fetch", {15'h0, mif.imem_req, mif.imem_addr}, 32'h0001_0100);
        push(EV_FETCH, 32'h0100); push(EV_RF, 32'h0100);
        issue(I_ADDI, 0, 0, 1, 0, '0, 0, 0, cyc, dreq, alu);
        check("post_rst_instret", instret, 32'd1);
        check("post_rst_pc", 32'(pc), 32'h0104);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
